// File: rtl/mig_tt_sweeper_if.sv
// Handshake and FUT-drive bundle for the truth-table sweeper.
// The slave modport is the sweeper itself; master is whoever starts sweeps,
// supplies the FUT output and consumes the result.
interface mig_tt_sweeper_if #(
    parameter int unsigned NVARS = 7
);
    logic                    start;
    logic [2**NVARS-1:0]     exp_tt;
    logic                    busy;
    logic [NVARS-1:0]        x_out;
    logic                    f_in;
    logic                    tt_valid;
    logic                    tt_ready;
    logic [2**NVARS-1:0]     tt_data;
    logic [NVARS:0]          ones;
    logic                    match;

    modport master (
        output start, exp_tt, f_in, tt_ready,
        input  busy, x_out, tt_valid, tt_data, ones, match
    );

    modport slave (
        input  start, exp_tt, f_in, tt_ready,
        output busy, x_out, tt_valid, tt_data, ones, match
    );
endinterface

// File: rtl/mig_tt_sweeper.sv
// Sequential truth-table extractor: walks all 2^NVARS minterms through an
// attached function under test, collects the output into a table, counts its
// ones and compares it with an expected table captured at start.
module mig_tt_sweeper #(
    parameter int unsigned LATENCY = 0,
    parameter int unsigned NVARS   = 7
) (
    input logic              clk,
    input logic              rst,
    mig_tt_sweeper_if.slave  bus
);
    localparam int unsigned TW = 2**NVARS;
    localparam logic [NVARS-1:0] LastIdx = '1;

    typedef enum logic [1:0] {StIdle, StSweep, StDrain, StDone} state_e;

    state_e            state_q, state_d;
    logic [NVARS-1:0]  x_out_q, x_out_d;
    logic [TW-1:0]     tt_data_q, tt_data_d;
    logic [TW-1:0]     exp_q, exp_d;
    logic [NVARS:0]    ones_q, ones_d;

    // Sample strobe and table index, aligned to the FUT's pipeline depth
    logic              samp_valid;
    logic [NVARS-1:0]  samp_idx;

    generate
        if (LATENCY == 0) begin : g_comb_fut
            assign samp_valid = (state_q == StSweep);
            assign samp_idx   = x_out_q;
        end else begin : g_pipe_fut
            logic [LATENCY-1:0]            pv_q;
            logic [LATENCY-1:0][NVARS-1:0] pi_q;

            // Shift the driven index along with a valid bit to match FUT latency
            always_ff @(posedge clk) begin
                if (rst) begin
                    pv_q <= '0;
                    pi_q <= '0;
                end else begin
                    pv_q[0] <= (state_q == StSweep);
                    pi_q[0] <= x_out_q;
                    for (int unsigned i = 1; i < LATENCY; i++) begin
                        pv_q[i] <= pv_q[i-1];
                        pi_q[i] <= pi_q[i-1];
                    end
                end
            end

            assign samp_valid = pv_q[LATENCY-1];
            assign samp_idx   = pi_q[LATENCY-1];
        end
    endgenerate

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            x_out_q   <= '0;
            tt_data_q <= '0;
            exp_q     <= '0;
            ones_q    <= '0;
        end else begin
            state_q   <= state_d;
            x_out_q   <= x_out_d;
            tt_data_q <= tt_data_d;
            exp_q     <= exp_d;
            ones_q    <= ones_d;
        end
    end

    // Next-state: sweep sequencing, handshake and sample capture
    always_comb begin
        state_d   = state_q;
        x_out_d   = x_out_q;
        tt_data_d = tt_data_q;
        exp_d     = exp_q;
        ones_d    = ones_q;

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    state_d   = StSweep;
                    exp_d     = bus.exp_tt;
                    tt_data_d = '0;
                    ones_d    = '0;
                    x_out_d   = '0;
                end
            end
            StSweep: begin
                // x_out parks on the last index through drain and done
                if (x_out_q == LastIdx) begin
                    state_d = (LATENCY == 0) ? StDone : StDrain;
                end else begin
                    x_out_d = x_out_q + 1'b1;
                end
            end
            StDrain: begin
                if (samp_valid && (samp_idx == LastIdx)) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (bus.tt_ready) begin
                    state_d = StIdle;
                    x_out_d = '0;
                end
            end
            default: state_d = StIdle;
        endcase

        if (samp_valid) begin
            tt_data_d[samp_idx] = bus.f_in;
            ones_d              = ones_q + (NVARS+1)'(bus.f_in);
        end
    end

    assign bus.busy     = (state_q == StSweep) || (state_q == StDrain);
    assign bus.tt_valid = (state_q == StDone);
    assign bus.x_out    = x_out_q;
    assign bus.tt_data  = tt_data_q;
    assign bus.ones     = ones_q;
    // Gated by valid so the idle/reset value is 0 even though both tables are 0
    assign bus.match    = (state_q == StDone) && (tt_data_q == exp_q);
endmodule
